// File: rtl/decode_scoreboard_if.sv
// decode_scoreboard_if: decode-side request and hazard/issue response bundle for decode_scoreboard.
interface decode_scoreboard_if #(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_sel;
  logic [NUM_SRC-1:0]        id_src_use;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_reg_write;
  logic                      id_mem_en;
  logic                      hold;
  logic                      flush;
  logic                      stall;
  logic                      issue;
  logic                      iss_reg_write;
  logic                      iss_mem_en;
  logic [2**REG_AW-1:0]      busy_mask;
  logic [CNT_W-1:0]          stall_cnt;
  modport master (
    output id_valid, id_src_sel, id_src_use, id_dst, id_reg_write, id_mem_en, hold, flush,
    input  stall, issue, iss_reg_write, iss_mem_en, busy_mask, stall_cnt
  );
  modport slave (
    input  id_valid, id_src_sel, id_src_use, id_dst, id_reg_write, id_mem_en, hold, flush,
    output stall, issue, iss_reg_write, iss_mem_en, busy_mask, stall_cnt
  );
endinterface

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: tracks in-flight destination registers, stalls decode on RAW hazards and qualifies issue.
module decode_scoreboard #(
  parameter int REG_AW    = 3,
  parameter int NUM_SRC   = 2,
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1,
  parameter int FLUSH_N   = 2,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  decode_scoreboard_if.slave sb
);
  // With WB forwarding the writeback entry never blocks a reader.
  localparam int LIM = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;
  logic [DEPTH-1:0]     v;
  logic [DEPTH-1:0]     wr;
  logic [REG_AW-1:0]    dst [DEPTH];
  logic [CNT_W-1:0]     cnt;
  logic [2**REG_AW-1:0] busy;
  logic                 hazard;
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      for (int i = 0; i < LIM; i++)
        if (sb.id_src_use[k] && v[i] && wr[i] && dst[i] == sb.id_src_sel[k*REG_AW +: REG_AW])
          hazard = 1'b1;
  end
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (v[i] && wr[i]) busy[dst[i]] = 1'b1;
  end
  assign sb.stall         = sb.id_valid & hazard & ~sb.flush;
  assign sb.issue         = sb.id_valid & ~hazard & ~sb.hold & ~sb.flush;
  assign sb.iss_reg_write = sb.id_reg_write & sb.issue;
  assign sb.iss_mem_en    = sb.id_mem_en & sb.issue;
  assign sb.busy_mask     = busy;
  assign sb.stall_cnt     = cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v   <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) dst[i] <= '0;
    end else begin
      if (sb.flush) v[0] <= 1'b0;
      else if (!sb.hold) begin
        v[0]   <= sb.issue;
        wr[0]  <= sb.id_reg_write;
        dst[0] <= sb.id_dst;
      end
      // Flush overrides hold for the young entries; older ones follow hold.
      for (int i = 1; i < DEPTH; i++)
        if (sb.flush && i < FLUSH_N) v[i] <= 1'b0;
        else if (!sb.hold) begin
          v[i]   <= v[i-1];
          wr[i]  <= wr[i-1];
          dst[i] <= dst[i-1];
        end
      if (sb.stall && !sb.hold && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: directed vectors into a queue, monitor compares DUT outputs every cycle.
module tb_decode_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  typedef struct {
    int    sel;
    string nm;
    int    f;
    int    busy;
    int    cnt;
  } exp_t;
  exp_t q[$];
  int passed = 0;
  int total  = 0;
  decode_scoreboard_if #(.REG_AW(3), .NUM_SRC(2), .CNT_W(16)) ifa ();
  decode_scoreboard_if #(.REG_AW(3), .NUM_SRC(2), .CNT_W(16)) ifb ();
  decode_scoreboard_if #(.REG_AW(3), .NUM_SRC(2), .CNT_W(2))  ifc ();
  decode_scoreboard dut_a (.clk(clk), .rst(rst), .sb(ifa));
  decode_scoreboard #(.WB_BYPASS(0)) dut_b (.clk(clk), .rst(rst), .sb(ifb));
  decode_scoreboard #(.CNT_W(2)) dut_c (.clk(clk), .rst(rst), .sb(ifc));

  task automatic step(input int sel, input string nm, input int v, input int a1, input int a0,
                      input int u, input int d, input int w, input int m, input int h,
                      input int f, input int r, input int ef, input int eb, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifa.id_valid = 1'(v);  ifb.id_valid = 1'(v);  ifc.id_valid = 1'(v);
    ifa.id_src_sel = {3'(a1), 3'(a0)};
    ifb.id_src_sel = {3'(a1), 3'(a0)};
    ifc.id_src_sel = {3'(a1), 3'(a0)};
    ifa.id_src_use = 2'(u);  ifb.id_src_use = 2'(u);  ifc.id_src_use = 2'(u);
    ifa.id_dst = 3'(d);  ifb.id_dst = 3'(d);  ifc.id_dst = 3'(d);
    ifa.id_reg_write = 1'(w);  ifb.id_reg_write = 1'(w);  ifc.id_reg_write = 1'(w);
    ifa.id_mem_en = 1'(m);  ifb.id_mem_en = 1'(m);  ifc.id_mem_en = 1'(m);
    ifa.hold = 1'(h);  ifb.hold = 1'(h);  ifc.hold = 1'(h);
    ifa.flush = 1'(f);  ifb.flush = 1'(f);  ifc.flush = 1'(f);
    e.sel = sel; e.nm = nm; e.f = ef; e.busy = eb; e.cnt = ec;
    q.push_back(e);
    if (r != 0) begin
      #1;
      rst = 1'b1;
    end
  endtask

  initial begin
    exp_t e;
    logic [27:0] act, req;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 0)
          act = {ifa.stall, ifa.issue, ifa.iss_reg_write, ifa.iss_mem_en, ifa.busy_mask, ifa.stall_cnt};
        else if (e.sel == 1)
          act = {ifb.stall, ifb.issue, ifb.iss_reg_write, ifb.iss_mem_en, ifb.busy_mask, ifb.stall_cnt};
        else
          act = {ifc.stall, ifc.issue, ifc.iss_reg_write, ifc.iss_mem_en, ifc.busy_mask, 14'b0, ifc.stall_cnt};
        req = {4'(e.f), 8'(e.busy), 16'(e.cnt)};
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: {stall,issue,irw,ime,busy,cnt} got %h expected %h", e.nm, act, req);
      end
    end
  end

  initial begin
    //   sel name           v a1 a0 use d w m h f r  flags    busy   cnt
    step(0, "idle_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 'h00, 0);
    step(0, "raw_prod",     1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 'b0110, 'h00, 0);
    step(0, "raw_stall1",   1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b1000, 'h08, 0);
    step(0, "raw_stall2",   1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b1000, 'h08, 1);
    step(0, "raw_issue",    1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b0110, 'h08, 2);
    step(0, "idle_a",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 'h10, 2);
    step(0, "unused_src",   1, 4, 5, 1, 6, 1, 0, 0, 0, 0, 'b0110, 'h10, 2);
    step(0, "self_dep",     1, 0, 7, 1, 7, 0, 1, 0, 0, 0, 'b0101, 'h50, 2);
    step(0, "idle_b",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 'h40, 2);
    step(0, "hold_prod",    1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 'b0110, 'h40, 2);
    step(0, "hold_stall",   1, 0, 2, 1, 1, 1, 0, 0, 0, 0, 'b1000, 'h04, 2);
    step(0, "hold_1",       1, 0, 2, 1, 1, 1, 0, 1, 0, 0, 'b1000, 'h04, 3);
    step(0, "hold_2",       1, 0, 2, 1, 1, 1, 0, 1, 0, 0, 'b1000, 'h04, 3);
    step(0, "hold_3",       1, 0, 2, 1, 1, 1, 0, 1, 0, 0, 'b1000, 'h04, 3);
    step(0, "hold_rel",     1, 0, 2, 1, 1, 1, 0, 0, 0, 0, 'b1000, 'h04, 3);
    step(0, "hold_issue",   1, 0, 2, 1, 1, 1, 0, 0, 0, 0, 'b0110, 'h04, 4);
    step(0, "idle_c",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 'h02, 4);
    step(0, "fl_prod",      1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 'b0110, 'h02, 4);
    step(0, "fl_flush",     1, 0, 2, 1, 5, 1, 1, 0, 1, 0, 'b0000, 'h06, 4);
    step(0, "fl_after",     1, 0, 2, 1, 5, 1, 1, 0, 0, 0, 'b0111, 'h00, 4);
    step(0, "idle_d",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 'h20, 4);
    step(0, "src1_stall",   1, 5, 0, 2, 0, 0, 0, 0, 0, 0, 'b1000, 'h20, 4);
    step(0, "async_rst",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b0000, 'h00, 0);
    step(0, "post_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 'h00, 0);
    step(1, "wb0_prod",     1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 'b0110, 'h00, 0);
    step(1, "wb0_stall1",   1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b1000, 'h08, 0);
    step(1, "wb0_stall2",   1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b1000, 'h08, 1);
    step(1, "wb0_stall3",   1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b1000, 'h08, 2);
    step(1, "wb0_issue",    1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b0110, 'h00, 3);
    step(1, "wb0_rst",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b0000, 'h00, 0);
    step(2, "sat_prod",     1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 'b0110, 'h00, 0);
    step(2, "sat_s1",       1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b1000, 'h08, 0);
    step(2, "sat_s2",       1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b1000, 'h08, 1);
    step(2, "sat_i1",       1, 0, 3, 1, 4, 1, 0, 0, 0, 0, 'b0110, 'h08, 2);
    step(2, "sat_s3",       1, 0, 4, 1, 5, 1, 0, 0, 0, 0, 'b1000, 'h10, 2);
    step(2, "sat_s4",       1, 0, 4, 1, 5, 1, 0, 0, 0, 0, 'b1000, 'h10, 3);
    step(2, "sat_i2",       1, 0, 4, 1, 5, 1, 0, 0, 0, 0, 'b0110, 'h10, 3);
    step(2, "sat_s5",       1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 'b1000, 'h20, 3);
    step(2, "sat_s6",       1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 'b1000, 'h20, 3);
    step(2, "sat_i3",       1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 'b0100, 'h20, 3);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
Parametrised hazard scoreboard for the decode stage.
- Replaces the ad-hoc per-signal regWrite/memEn suppression state machines with explicit tracking of in-flight destination registers.
- Sits between fetch/decode and the ID/EX pipeline register. Detects RAW hazards on up to NUM_SRC source operands, stalls decode until the producer reaches writeback, and qualifies regWrite/memEn for the issuing instruction.
- Supports pipeline hold, flush of young entries, a per-register busy mask and a saturating stall counter.

Parameters:
REG_AW, 3, register address width; 2**REG_AW architectural registers.
NUM_SRC, 2, number of source operands checked per instruction.
DEPTH, 3, issue-to-writeback stages tracked (entry DEPTH-1 = WB stage); minimum 2.
WB_BYPASS, 1, 1 = register file forwards the WB write to same-cycle reads, so entry DEPTH-1 is excluded from hazard compare.
FLUSH_N, 2, number of youngest entries (index 0..FLUSH_N-1) cleared by flush; 1..DEPTH.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
id_valid  in  1  decode holds a valid instruction.
id_src_sel  in  NUM_SRC*REG_AW  source register addresses; operand k occupies bits [k*REG_AW +: REG_AW].
id_src_use  in  NUM_SRC  operand k is actually read.
id_dst  in  REG_AW  destination register (already resolved from regDst).
id_reg_write  in  1  instruction writes id_dst.
id_mem_en  in  1  instruction accesses memory.
hold  in  1  global pipeline freeze (flop_stall): no shift, no issue, no count.
flush  in  1  discard entries 0..FLUSH_N-1 (branch mispredict).
stall  out  1  decode must not advance; combinational.
issue  out  1  instruction accepted this cycle; combinational.
iss_reg_write  out  1  id_reg_write & issue.
iss_mem_en  out  1  id_mem_en & issue.
busy_mask  out  2**REG_AW  bit r set if any tracked entry holds a pending write to r; registered view of entries.
stall_cnt  out  CNT_W  cycles with stall=1 and hold=0; saturates at all-ones.

Behaviour:
- State: DEPTH entries {v, wr, dst}. Entry 0 = youngest (EX), entry DEPTH-1 = WB.
- Reset (async): all entries v=0, wr=0, dst=0; stall_cnt=0; busy_mask=0. With id_valid=0, stall=issue=iss_*=0.
- Hazard, per k: id_src_use[k] & any entry i (i < DEPTH-1 if WB_BYPASS else i < DEPTH) with v & wr & dst==src_k. OR over k.
- stall = id_valid & hazard & ~flush.
- issue = id_valid & ~hazard & ~hold & ~flush.
- Per rising clk, priority rst > flush > hold > normal:
  - flush: entries 0..FLUSH_N-1 cleared (v=0); older entries hold if hold=1, otherwise shift normally. Bubble inserted at entry 0. Flush with hold=1 still clears.
  - hold (no flush): all entries and stall_cnt frozen.
  - normal: entry i+1 <= entry i; entry DEPTH-1 retires. Entry 0 <= {issue, id_reg_write, id_dst} if issue, else bubble (v=0).
- Stall counter: stall_cnt <= stall_cnt+1 when stall & ~hold and not saturated.
- Latency: a producer issued at cycle t blocks dependents for DEPTH-1 cycles (WB_BYPASS=1) or DEPTH cycles (WB_BYPASS=0).
- Self-dependence (src == dst of the same instruction) is not a hazard.
- Multiple entries may target the same dst; the hazard persists until all of them pass the compare window.
- id_valid=0 never stalls and never counts; iss_* are 0.

Test Plan:
- Reset mid-operation: entries populated, assert rst asynchronously between edges -> busy_mask=0, stall_cnt=0 immediately, without waiting for a clock edge.
- RAW, defaults: cycle 0 issue wr r3; cycle 1 id_src_sel r3 (use=01) -> stall=1 at cycles 1,2, issue at cycle 3, stall_cnt=2, busy_mask[3]=1 at cycles 1-3.
- WB_BYPASS=0, same stimulus -> stall at cycles 1-3, issue at cycle 4, stall_cnt=3.
- Unused operand: src1=r3 with id_src_use=01 (only src0=r5 used) after a write to r3 -> no stall; iss_reg_write follows id_reg_write.
- Hold: dependent stalled at cycle 1, hold=1 for cycles 2-4 -> entries frozen, stall_cnt stays 1, issue=0; hold released at cycle 5 -> stall at cycle 5, issue at cycle 6.
- Flush: producer of r2 in entry 0, flush=1 with a dependent in decode -> issue=0, entry cleared; next cycle the dependent issues without stall. Saturation with CNT_W=2: 5 stall cycles -> stall_cnt=3.
